// File: rtl/core_pkg.sv
// Types and constants shared by the instruction-fetch slice.
// A fetch entry pairs an instruction with the PC it was fetched from.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous clear and an occupancy count.
// Storage is not reset; only the pointers and the count are.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: credit-limited in-order imem requests, PC tagging of
// responses, a decode-facing buffer, and flush handling with in-flight drops.
module if_fetch_buffer #(
    parameter int              XLEN      = core_pkg::XLEN,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            pc_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    import core_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] data_count;
    logic             data_full;
    logic             data_empty;
    logic [XLEN-1:0]  tag_head;
    logic [CNT_W-1:0] tag_count;
    logic             tag_full;
    logic             tag_empty;

    fetch_entry_t     entry_in;
    fetch_entry_t     head;
    logic [CNT_W:0]   inflight;
    logic             accept;
    logic             deliver;
    logic             id_pop;

    // Credit uses the registered count only, so a same-cycle pop frees nothing.
    assign inflight  = {1'b0, data_count} + {1'b0, outstanding_q};
    assign imem_req  = !rst && !flush && (inflight < (CNT_W + 1)'(DEPTH));
    assign imem_addr = pc_in;
    assign accept    = imem_req && imem_gnt;

    always_comb begin
        pc_stall = !accept;
        if (rst) begin
            pc_stall = 1'b1;
        end else if (flush) begin
            pc_stall = 1'b0;
        end
    end

    // Responses owed to a flushed stream carry no tag (the queue was cleared),
    // so only delivered responses consume a tag.
    assign deliver = imem_rvalid && (drop_cnt_q == '0) && !flush;
    assign id_pop  = id_valid && id_ready && !flush;

    assign entry_in.pc    = tag_head;
    assign entry_in.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(XLEN)
    ) u_tag_q (
        .clk    (clk),
        .rst    (rst),
        .clear_i(flush),
        .push_i (accept),
        .pop_i  (deliver),
        .data_i (pc_in),
        .data_o (tag_head),
        .full_o (tag_full),
        .empty_o(tag_empty),
        .count_o(tag_count)
    );

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_data_q (
        .clk    (clk),
        .rst    (rst),
        .clear_i(flush),
        .push_i (deliver),
        .pop_i  (id_pop),
        .data_i (entry_in),
        .data_o (head),
        .full_o (data_full),
        .empty_o(data_empty),
        .count_o(data_count)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // A response landing in the flush cycle is itself dropped, hence the -1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = imem_rvalid ? (outstanding_q - CNT_W'(1)) : outstanding_q;
        end else if (imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign id_valid = !data_empty;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? head.pc : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(deliver && data_full));
    a_tag_present: assert property (@(posedge clk) disable iff (rst)
        !(deliver && tag_empty));
    a_tag_room: assert property (@(posedge clk) disable iff (rst)
        !(accept && tag_full));
    a_tag_balance: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, tag_count} + {1'b0, drop_cnt_q}) == {1'b0, outstanding_q});

endmodule
